// File: rtl/crop_pkg.sv
// Shared types for the crop sequencer: FSM states, coordinate types,
// and crop-size helper.
package crop_pkg;

  localparam int ROW_W = 10;
  localparam int COL_W = 10;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    DONE
  } state_t;

  function automatic int crop_pixels(
    input int rows,
    input int cols
  );
    return rows * cols;
  endfunction

endpackage

// File: rtl/crop_origin_table.sv
// Origin register file: appends entries at the fill count,
// reads by crop index, reports full.
module crop_origin_table #(
  parameter int N = 8,
  parameter int W = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr,
  input  logic [W-1:0]         i_wdata,
  input  logic                 i_clr,
  input  logic [$clog2(N)-1:0] i_rd_idx,
  output logic [W-1:0]         o_rdata,
  output logic [$clog2(N):0]   o_count,
  output logic                 o_full
);

  localparam int IW = $clog2(N);

  logic [W-1:0] r_mem [N];
  logic [IW:0]  r_count;
  logic         w_we;

  assign w_we    = i_wr && !o_full;
  assign o_full  = r_count[IW];
  assign o_count = r_count;
  assign o_rdata = r_mem[i_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (w_we) begin
      r_count <= r_count + (IW+1)'(1);
    end
  end

  // contents survive reset; only the count is rearmed
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_count[IW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/crop_sequencer.sv
// Sequences the crop engine through a table of origins.
// Define CROP_SEQ_CLAMP_EN to clamp origins into the input frame.
module crop_sequencer
  import crop_pkg::*;
#(
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int MAX_CROPS        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] cfg_TDATA,
  input  logic                          cfg_TVALID,
  output logic                          cfg_TREADY,
  input  logic                          start,
  output logic [IMG_ROW_BITWIDTH-1:0]   crop_Y1_TDATA,
  output logic                          crop_Y1_TVALID,
  input  logic                          crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0]   crop_X1_TDATA,
  output logic                          crop_X1_TVALID,
  input  logic                          crop_X1_TREADY,
  input  logic                          mon_TVALID,
  input  logic                          mon_TREADY,
  output logic [$clog2(MAX_CROPS)-1:0]  crop_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          clamp_err
);

  localparam int RW  = IMG_ROW_BITWIDTH;
  localparam int CW  = IMG_COL_BITWIDTH;
  localparam int IW  = $clog2(MAX_CROPS);
  localparam int NW  = IW + 1;
  localparam int PIX = crop_pixels(OUT_ROWS, OUT_COLS);
  localparam int PW  = $clog2(PIX + 1);
  localparam logic [RW-1:0] Y_MAX = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] X_MAX = CW'(IN_COLS - OUT_COLS);
`ifdef CROP_SEQ_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t         r_state, w_state_nxt;
  logic [IW-1:0]  r_idx, w_idx_nxt;
  logic [PW-1:0]  r_pix, w_pix_nxt;
  logic           r_yv, w_yv_nxt;
  logic           r_xv, w_xv_nxt;
  logic           r_clamp, w_clamp_nxt;
  logic           w_wr, w_clr, w_full;
  logic [NW-1:0]  w_count, w_count_nxt;
  logic [RW+CW-1:0] w_entry;
  logic [RW-1:0]  w_y_raw;
  logic [CW-1:0]  w_x_raw;
  logic           w_y_over, w_x_over;
  logic           w_beat, w_last_pix, w_last_crop;

  crop_origin_table #(
    .N(MAX_CROPS),
    .W(RW + CW)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (w_wr),
    .i_wdata  (cfg_TDATA),
    .i_clr    (w_clr),
    .i_rd_idx (r_idx),
    .o_rdata  (w_entry),
    .o_count  (w_count),
    .o_full   (w_full)
  );

  assign cfg_TREADY  = (r_state == IDLE) && !w_full && !reset;
  assign w_wr        = cfg_TVALID && cfg_TREADY;
  assign w_count_nxt = w_count + NW'(w_wr);

  assign w_y_raw  = w_entry[RW+CW-1:CW];
  assign w_x_raw  = w_entry[CW-1:0];
  assign w_y_over = CLAMP_EN && (w_y_raw > Y_MAX);
  assign w_x_over = CLAMP_EN && (w_x_raw > X_MAX);

  assign crop_Y1_TDATA  = w_y_over ? Y_MAX : w_y_raw;
  assign crop_X1_TDATA  = w_x_over ? X_MAX : w_x_raw;
  assign crop_Y1_TVALID = r_yv;
  assign crop_X1_TVALID = r_xv;
  assign crop_idx       = r_idx;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign clamp_err      = r_clamp;

  assign w_beat      = mon_TVALID && mon_TREADY;
  assign w_last_pix  = (r_pix == PW'(PIX - 1));
  assign w_last_crop = (NW'(r_idx) == w_count - NW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pix_nxt   = r_pix;
    w_yv_nxt    = r_yv;
    w_xv_nxt    = r_xv;
    w_clamp_nxt = r_clamp;
    w_clr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // a cfg beat in the start cycle counts toward the table
        if (start && (w_count_nxt != '0)) begin
          w_state_nxt = ISSUE;
          w_idx_nxt   = '0;
          w_pix_nxt   = '0;
          w_yv_nxt    = 1'b1;
          w_xv_nxt    = 1'b1;
          w_clamp_nxt = 1'b0;
        end
      end
      ISSUE: begin
        w_clamp_nxt = r_clamp | w_y_over | w_x_over;
        if (r_yv && crop_Y1_TREADY) w_yv_nxt = 1'b0;
        if (r_xv && crop_X1_TREADY) w_xv_nxt = 1'b0;
        if (!w_yv_nxt && !w_xv_nxt) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_beat) begin
          if (!w_last_pix) begin
            w_pix_nxt = r_pix + PW'(1);
          end else if (w_last_crop) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_idx_nxt   = r_idx + IW'(1);
            w_pix_nxt   = '0;
            w_yv_nxt    = 1'b1;
            w_xv_nxt    = 1'b1;
          end
        end
      end
      DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pix   <= '0;
      r_yv    <= 1'b0;
      r_xv    <= 1'b0;
      r_clamp <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pix   <= w_pix_nxt;
      r_yv    <= w_yv_nxt;
      r_xv    <= w_xv_nxt;
      r_clamp <= w_clamp_nxt;
    end
  end

endmodule

// File: tb/tb_crop_sequencer.sv
// Scoreboard bench for crop_sequencer: random monitor traffic,
// stray pulses, full table, clamp and mid-run reset.
module tb_crop_sequencer;

  localparam int PIX = 48 * 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cfg_TDATA = '0;
  logic        cfg_TVALID = 1'b0;
  logic        cfg_TREADY;
  logic        start = 1'b0;
  logic [9:0]  crop_Y1_TDATA;
  logic        crop_Y1_TVALID;
  logic        crop_Y1_TREADY = 1'b0;
  logic [9:0]  crop_X1_TDATA;
  logic        crop_X1_TVALID;
  logic        crop_X1_TREADY = 1'b0;
  logic        mon_TVALID = 1'b0;
  logic        mon_TREADY = 1'b0;
  logic [2:0]  crop_idx;
  logic        busy, done, clamp_err;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;
  bit exp_done = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [9:0] v;
  } exp_t;

  exp_t yq[$];
  exp_t xq[$];
  logic [19:0] e[8];

  always #5 clk = ~clk;

  crop_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_TDATA      (cfg_TDATA),
    .cfg_TVALID     (cfg_TVALID),
    .cfg_TREADY     (cfg_TREADY),
    .start          (start),
    .crop_Y1_TDATA  (crop_Y1_TDATA),
    .crop_Y1_TVALID (crop_Y1_TVALID),
    .crop_Y1_TREADY (crop_Y1_TREADY),
    .crop_X1_TDATA  (crop_X1_TDATA),
    .crop_X1_TVALID (crop_X1_TVALID),
    .crop_X1_TREADY (crop_X1_TREADY),
    .mon_TVALID     (mon_TVALID),
    .mon_TREADY     (mon_TREADY),
    .crop_idx       (crop_idx),
    .busy           (busy),
    .done           (done),
    .clamp_err      (clamp_err)
  );

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // reference origin: frame limits are 100-48 rows, 160-48 cols
  function automatic logic [9:0] ey(input logic [9:0] y);
`ifdef CROP_SEQ_CLAMP_EN
    return (y > 10'd52) ? 10'd52 : y;
`else
    return y;
`endif
  endfunction

  function automatic logic [9:0] ex(input logic [9:0] x);
`ifdef CROP_SEQ_CLAMP_EN
    return (x > 10'd112) ? 10'd112 : x;
`else
    return x;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (crop_Y1_TVALID) begin
        check("y_queue_nonempty", 32'(yq.size() != 0), 1);
        if (yq.size() != 0) begin
          check("y1_data", crop_Y1_TDATA, yq[0].v);
          check("y1_idx", crop_idx, yq[0].idx);
          if (crop_Y1_TREADY) void'(yq.pop_front());
        end
      end
      if (crop_X1_TVALID) begin
        check("x_queue_nonempty", 32'(xq.size() != 0), 1);
        if (xq.size() != 0) begin
          check("x1_data", crop_X1_TDATA, xq[0].v);
          check("x1_idx", crop_idx, xq[0].idx);
          if (crop_X1_TREADY) void'(xq.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        check("done_expected", exp_done, 1);
      end
      check("cfg_rdy_while_busy", busy && cfg_TREADY, 0);
    end
  end

  task automatic run_seq(input int n, input logic [19:0] ent[8],
                         input int xdly, input bit rnd, input bit cat,
                         input int abort_at);
    bit clamp_any;
    int cnt;
    int k;
    clamp_any = 0;
    for (int i = 0; i < n; i++) begin
      check("cfg_ready", cfg_TREADY, 1);
      cfg_TVALID = 1'b1;
      cfg_TDATA  = ent[i];
      if (cat && i == n - 1) start = 1'b1;
      @(posedge clk); #1;
      cfg_TVALID = 1'b0;
    end
    if (n == 8) begin
      check("cfg_full", cfg_TREADY, 0);
      cfg_TVALID = 1'b1;
      cfg_TDATA  = '1;
      @(posedge clk); #1;
      cfg_TVALID = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      yq.push_back({3'(i), ey(ent[i][19:10])});
      xq.push_back({3'(i), ex(ent[i][9:0])});
      if (ey(ent[i][19:10]) != ent[i][19:10] ||
          ex(ent[i][9:0]) != ent[i][9:0]) clamp_any = 1;
    end
    if (!cat) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("start_latency", {crop_Y1_TVALID, crop_X1_TVALID}, 2'b11);
    check("busy_on_start", busy, 1);
    for (int c = 0; c < n; c++) begin
      k = 0;
      crop_Y1_TREADY = 1'b1;
      crop_X1_TREADY = (xdly == 0);
      while (crop_Y1_TVALID || crop_X1_TVALID) begin
        if (k > 60) begin
          check("handshake_timeout", k, 0);
          break;
        end
        check("issue_busy", busy, 1);
        mon_TVALID = 1'($urandom % 2);
        mon_TREADY = 1'($urandom % 2);
        start      = ($urandom % 4 == 0);
        @(posedge clk); #1;
        k++;
        crop_X1_TREADY = (k >= xdly);
      end
      mon_TVALID = 1'b0;
      mon_TREADY = 1'b0;
      start = 1'b0;
      crop_Y1_TREADY = 1'b0;
      crop_X1_TREADY = 1'b0;
      cnt = 0;
      while (cnt < PIX) begin
        if (rnd) begin
          mon_TVALID = 1'($urandom % 2);
          mon_TREADY = 1'($urandom % 2);
          start      = ($urandom % 32 == 0);
        end else begin
          mon_TVALID = 1'b1;
          mon_TREADY = 1'b1;
        end
        if (mon_TVALID && mon_TREADY) cnt++;
        @(posedge clk); #1;
        if (abort_at > 0 && cnt == abort_at) begin
          reset = 1'b1;
          mon_TVALID = 1'b0;
          mon_TREADY = 1'b0;
          start = 1'b0;
          yq.delete();
          xq.delete();
          @(posedge clk); #1;
          check("rst_y_valid", crop_Y1_TVALID, 0);
          check("rst_x_valid", crop_X1_TVALID, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_idx", crop_idx, 0);
          check("rst_cfg_ready", cfg_TREADY, 0);
          reset = 1'b0;
          @(posedge clk); #1;
          check("post_rst_cfg_ready", cfg_TREADY, 1);
          return;
        end
      end
      mon_TVALID = 1'b0;
      mon_TREADY = 1'b0;
      start = 1'b0;
      if (c == n - 1) begin
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        exp_done = 1;
        done_exp++;
        @(posedge clk); #1;
        exp_done = 0;
        check("done_single", done, 0);
        check("busy_after_done", busy, 0);
      end else begin
        check("next_issue", {crop_Y1_TVALID, crop_X1_TVALID}, 2'b11);
        check("next_idx", crop_idx, c + 1);
      end
    end
    check("clamp_err", clamp_err, 32'(clamp_any));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("empty_start_ignored", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_y_valid", crop_Y1_TVALID, 0);
    check("reset_x_valid", crop_X1_TVALID, 0);
    check("reset_cfg_ready", cfg_TREADY, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_clamp", clamp_err, 0);
    check("reset_idx", crop_idx, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    e[0] = {10'd10, 10'd10};
    run_seq(1, e, 0, 0, 0, 0);

    e[0] = {10'd0, 10'd0};
    e[1] = {10'd20, 10'd30};
    e[2] = {10'd52, 10'd112};
    run_seq(3, e, 5, 0, 0, 0);

    for (int i = 0; i < 8; i++) e[i] = {10'(i * 7), 10'(i * 15)};
    run_seq(8, e, 1, 0, 0, 0);

    e[0] = {10'd90, 10'd150};
    run_seq(1, e, 0, 0, 0, 0);

    for (int i = 0; i < 2; i++)
      e[i] = {10'($urandom_range(0, 99)), 10'($urandom_range(0, 159))};
    run_seq(2, e, 2, 1, 0, 0);

    e[0] = {10'd5, 10'd6};
    e[1] = {10'd7, 10'd8};
    run_seq(2, e, 0, 0, 0, 1000);

    e[0] = {10'd33, 10'd44};
    run_seq(1, e, 3, 0, 1, 0);

    check("done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crop_sequencer.md
Name: crop_sequencer

Overview:
- Controller that sequences the crop datapath (crop_plus_fifo) through a programmed list of crop origins for one input frame.
- Holds a table of up to MAX_CROPS (Y1,X1) origins loaded over a config stream. On start it issues one origin pair per crop on the crop_Y1/crop_X1 streams.
- Counts accepted output pixels to detect crop completion, then issues the next origin. Sits between the host/config logic and the crop engine.

Parameters:
- IN_ROWS, 100, input frame rows
- IN_COLS, 160, input frame columns
- OUT_ROWS, 48, crop rows
- OUT_COLS, 48, crop columns
- IMG_ROW_BITWIDTH, 10, width of Y coordinate
- IMG_COL_BITWIDTH, 10, width of X coordinate
- MAX_CROPS, 8, origin table depth (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cfg_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  {Y1,X1}; Y1 in the MSBs
- cfg_TVALID  in  1  config entry valid
- cfg_TREADY  out  1  table can accept an entry
- start  in  1  single-cycle pulse that begins sequencing
- crop_Y1_TDATA  out  IMG_ROW_BITWIDTH  crop row origin
- crop_Y1_TVALID  out  1
- crop_Y1_TREADY  in  1
- crop_X1_TDATA  out  IMG_COL_BITWIDTH  crop column origin
- crop_X1_TVALID  out  1
- crop_X1_TREADY  in  1
- mon_TVALID  in  1  monitored crop-engine pixel_out_TVALID
- mon_TREADY  in  1  monitored crop-engine pixel_out_TREADY
- crop_idx  out  $clog2(MAX_CROPS)  index of the active crop
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last crop completes
- clamp_err  out  1  sticky; set when any issued origin was clamped

Behaviour:
- Reset (synchronous, active-high) values:
  - All TVALIDs 0, cfg_TREADY 0, busy 0, done 0, clamp_err 0, crop_idx 0.
  - Table count 0, pixel counter 0, state IDLE.
  - Table contents are not cleared.
- Reset mid-operation aborts the sequence immediately. No done pulse is generated.
- States:
  - IDLE: cfg_TREADY = (count < MAX_CROPS). Each cfg beat writes table[count] and increments count.
    - start with count>0 -> ISSUE, with crop_idx=0 and clamp_err cleared.
    - start with count==0 is ignored.
    - start and a cfg beat in the same cycle: the entry is written, and the new count is used.
  - ISSUE: both TVALIDs are asserted together, with TDATA taken from table[crop_idx].
    - Each TVALID drops the cycle after its own handshake; TDATA stays stable while TVALID is high.
    - Go to RUN once both handshakes have completed (same cycle or different cycles).
    - The pixel counter is zeroed on entry to ISSUE.
  - RUN: the pixel counter increments on mon_TVALID & mon_TREADY.
    - On the beat where the counter equals OUT_ROWS*OUT_COLS-1: if crop_idx == count-1 go to DONE; otherwise crop_idx+1 and go to ISSUE.
  - DONE: done=1 for one cycle, then go to IDLE with count reset to 0 (table rearmed for the next load).
- Timing and widths:
  - Monitor beats outside RUN are ignored.
  - The pixel counter is $clog2(OUT_ROWS*OUT_COLS+1) bits and never wraps.
  - start pulses outside IDLE are ignored.
  - cfg_TREADY is 0 outside IDLE.
  - Latency: start -> TVALID high is 1 cycle. The last crop pixel beat -> next TVALID high (or done) is 1 cycle.

Optional Feature:
- Macro CROP_SEQ_CLAMP_EN.
- Defined:
  - Issued Y1 is limited to min(Y1, IN_ROWS-OUT_ROWS) and X1 to min(X1, IN_COLS-OUT_COLS).
  - clamp_err is set in the cycle an origin is loaded into TDATA if either coordinate was reduced.
- Undefined:
  - Coordinates pass through unmodified.
  - clamp_err is tied to 0.

Decomposition:
- Package crop_pkg:
  - State enum typedef (IDLE, ISSUE, RUN, DONE).
  - Coordinate typedefs row_t/col_t.
  - Function crop_pixels(OUT_ROWS,OUT_COLS).
- One natural sub-module, crop_origin_table: MAX_CROPS-entry register file with write pointer/count, read by crop_idx, and a full flag.

Test Plan:
- Load 1 entry (10,10), then start; both TREADYs held high.
  -> Y1=X1=10 issued 1 cycle after start. After 2304 monitored beats, done pulses once, busy drops, and count is 0.
- Load 3 entries (0,0),(20,30),(52,112); X1_TREADY delayed 5 cycles after Y1_TREADY.
  -> Each origin is issued in order with crop_idx 0,1,2. State stays in ISSUE until both handshakes complete. done follows the 3rd crop's 2304th beat.
- Load 8 entries.
  -> cfg_TREADY goes 0 after the 8th beat. A 9th cfg_TVALID is not accepted and the table is unchanged.
- CROP_SEQ_CLAMP_EN defined: entry (90,150).
  -> Issued Y1=52, X1=112, clamp_err=1. Macro undefined -> 90/150 are issued and clamp_err=0.
- Random mon_TVALID/mon_TREADY with 2 crops, plus stray start and monitor beats during IDLE/ISSUE.
  -> Exactly 2304 beats are counted per crop, and strays have no effect.
- Reset asserted in RUN at beat 1000.
  -> Next cycle: TVALIDs 0, busy 0, no done. A new load and start runs normally from crop 0.
